// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two byte-enabled write ports and the busy-set port.
// Handshake: none. Every signal is sampled on every rising clk edge; writes and bset are always accepted.
interface reg_file_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);
  localparam int NB = XLEN / 8;

  logic [NRD*AW-1:0]   rs;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;

  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [NB-1:0]       wr0_be;
  logic [XLEN-1:0]     wr0_data;

  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [NB-1:0]       wr1_be;
  logic [XLEN-1:0]     wr1_data;

  logic                bset_en;
  logic [AW-1:0]       bset_addr;

  modport master (
    output rs, wr0_en, wr0_addr, wr0_be, wr0_data,
    output wr1_en, wr1_addr, wr1_be, wr1_data, bset_en, bset_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  rs, wr0_en, wr0_addr, wr0_be, wr0_data,
    input  wr1_en, wr1_addr, wr1_be, wr1_data, bset_en, bset_addr,
    output rdata, rbusy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational reads, two byte-enabled write ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_mp_if.slave   bus
);
  localparam int AW = $clog2(NREG);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] mem     [NREG];
  logic [XLEN-1:0] mem_nxt [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] wr_hit;

  // Post-edge image of every register; wr1 is applied last so it wins per byte.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      mem_nxt[r] = mem[r];
      wr_hit[r]  = 1'b0;
      if (r != 0) begin
        if (bus.wr0_en && bus.wr0_addr == AW'(r)) begin
          wr_hit[r] = 1'b1;
          for (int b = 0; b < NB; b++)
            if (bus.wr0_be[b]) mem_nxt[r][b*8 +: 8] = bus.wr0_data[b*8 +: 8];
        end
        if (bus.wr1_en && bus.wr1_addr == AW'(r)) begin
          wr_hit[r] = 1'b1;
          for (int b = 0; b < NB; b++)
            if (bus.wr1_be[b]) mem_nxt[r][b*8 +: 8] = bus.wr1_data[b*8 +: 8];
        end
      end
    end
    // A new producer is younger than the completing write, so set beats clear.
    busy_nxt = busy & ~wr_hit;
    if (bus.bset_en && bus.bset_addr != '0) busy_nxt[bus.bset_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
      busy <= '0;
    end else begin
      mem  <= mem_nxt;
      busy <= busy_nxt;
    end
  end

  // Bypassed busy ignores this cycle's bset so an instruction never stalls on itself.
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rst_n && bus.rs[i*AW +: AW] != '0) begin
        if (BYPASS != 0) begin
          bus.rdata[i*XLEN +: XLEN] = mem_nxt[bus.rs[i*AW +: AW]];
          bus.rbusy[i] = busy[bus.rs[i*AW +: AW]] & ~wr_hit[bus.rs[i*AW +: AW]];
        end else begin
          bus.rdata[i*XLEN +: XLEN] = mem[bus.rs[i*AW +: AW]];
          bus.rbusy[i] = busy[bus.rs[i*AW +: AW]];
        end
      end
    end
  end
endmodule
